// File: rtl/filter.sv
// Single-bit glitch/debounce filter: sig_out follows sig_in only after DEPTH equal samples.
// Optional FILTER_SYNC_EN adds a 2-flop input synchronizer (+2 cycles latency).
module filter #(
    parameter int DEPTH = 4
) (
    output logic sig_out,
    input  logic clock,
    input  logic reset,
    input  logic sig_in
);

    logic             sample;
    logic [DEPTH-1:0] win;
    logic [DEPTH-1:0] nxt;
    logic             all_one;
    logic             all_zero;

`ifdef FILTER_SYNC_EN
    logic meta;
    logic sync;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= sig_in;
            sync <= meta;
        end
    end

    assign sample = sync;
`else
    assign sample = sig_in;
`endif

    // The oldest bit is shifted out before it is ever compared.
    assign nxt      = {win[DEPTH-2:0], sample};
    assign all_one  = &nxt;
    assign all_zero = ~|nxt;

    always_ff @(posedge clock) begin
        if (reset) begin
            win     <= '0;
            sig_out <= 1'b0;
        end else begin
            win <= nxt;
            if (all_one) begin
                sig_out <= 1'b1;
            end else if (all_zero) begin
                sig_out <= 1'b0;
            end
        end
    end

    logic unused_msb;
    assign unused_msb = win[DEPTH-1];

endmodule

// File: tb/tb_filter.sv
// Directed and model-checked bench for the glitch filter.
module tb_filter;

    localparam int DEPTH = 4;

    logic clk;
    logic reset;
    logic sig_in;
    logic sig_out;

    int n_vec;
    int n_err;

    filter #(.DEPTH(DEPTH)) dut (
        .sig_out(sig_out),
        .clock  (clk),
        .reset  (reset),
        .sig_in (sig_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after each rising edge, outputs are sampled there too.
    task automatic tick(input logic r, input logic d);
        reset  = r;
        sig_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] exp_up;
        exp_up = 4'b1000;
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b1);
            n_vec++;
            if (sig_out !== 1'b0) begin
                n_err++;
                $display("FAIL reset_hold[%0d]: got %b want 0", i, sig_out);
            end
        end
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b1);
            n_vec++;
            if (sig_out !== exp_up[i]) begin
                n_err++;
                $display("FAIL reset_rise[%0d]: got %b want %b", i, sig_out, exp_up[i]);
            end
        end
    endtask

    task automatic test_glitch_high();
        logic [7:0] pat;
        pat = 8'b0111_0111;
        tick(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, pat[i]);
            n_vec++;
            if (sig_out !== 1'b0) begin
                n_err++;
                $display("FAIL glitch_high[%0d]: got %b want 0", i, sig_out);
            end
        end
    endtask

    task automatic test_fall();
        logic [7:0] pat;
        logic [7:0] exp_o;
        pat   = 8'b0000_1000;
        exp_o = 8'b0111_1111;
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1);
        n_vec++;
        if (sig_out !== 1'b1) begin
            n_err++;
            $display("FAIL fall_setup: got %b want 1", sig_out);
        end
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, pat[i]);
            n_vec++;
            if (sig_out !== exp_o[i]) begin
                n_err++;
                $display("FAIL fall[%0d]: got %b want %b", i, sig_out, exp_o[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] exp_up;
        exp_up = 4'b1000;
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1);
        n_vec++;
        if (sig_out !== 1'b1) begin
            n_err++;
            $display("FAIL mid_setup: got %b want 1", sig_out);
        end
        tick(1'b1, 1'b1);
        n_vec++;
        if (sig_out !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset: got %b want 0", sig_out);
        end
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b1);
            n_vec++;
            if (sig_out !== exp_up[i]) begin
                n_err++;
                $display("FAIL mid_rise[%0d]: got %b want %b", i, sig_out, exp_up[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [DEPTH-1:0] mw;
        logic [DEPTH-1:0] nx;
        logic             mo;
        logic             d;
        int               bad;
        bad = 0;
        tick(1'b1, 1'b0);
        mw = '0;
        mo = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            d  = 1'($urandom_range(0, 1));
            nx = {mw[DEPTH-2:0], d};
            mw = nx;
            if (nx == '1) mo = 1'b1;
            else if (nx == '0) mo = 1'b0;
            tick(1'b0, d);
            n_vec++;
            if (sig_out !== mo) begin
                n_err++;
                if (bad < 10)
                    $display("FAIL random[%0d]: got %b want %b", i, sig_out, mo);
                bad++;
            end
        end
    endtask

    task automatic test_sync();
        logic [5:0] exp_up;
        exp_up = 6'b10_0000;
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 1'b1);
            n_vec++;
            if (sig_out !== exp_up[i]) begin
                n_err++;
                $display("FAIL sync_rise[%0d]: got %b want %b", i, sig_out, exp_up[i]);
            end
        end
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 1'b0);
            n_vec++;
            if (sig_out !== ~exp_up[i]) begin
                n_err++;
                $display("FAIL sync_fall[%0d]: got %b want %b", i, sig_out, ~exp_up[i]);
            end
        end
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        reset  = 1'b1;
        sig_in = 1'b0;
        @(posedge clk);
        #1;
`ifdef FILTER_SYNC_EN
        test_sync();
`else
        test_reset();
        test_glitch_high();
        test_fall();
        test_reset_mid();
        test_random();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
